// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and the baud divisor helper used by both receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled.
// clr restarts the phase so the first tick lands DIV clocks after release.
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Phase counter; wraps at DIV-1, held when disabled, zeroed on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 oversampling UART receiver with glitch-start rejection and framing
// error detection. Each bit is the majority of three samples around mid-bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxs
// ST_START | validating the start bit at its middle
// ST_DATA  | shifting in 8 data bits, LSB first
// ST_STOP  | checking the stop bit; good byte or framing error
// ST_BREAK | after a framing error, wait for one full bit time of high
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       rxfinish,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_M0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_M1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_M2   = SW'(OVERSAMPLE / 2 + 1);

  rx_state_t     state, state_nxt;
  logic [1:0]    sync;
  logic          rxs, rxs_prev;
  logic          tick, clr;
  logic [SW-1:0] scnt, scnt_nxt, scnt_inc;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          samp_a, samp_b, maj, mid;
  logic          fin_nxt, ferr_nxt;

  assign rxs      = sync[1];
  assign busy     = (state != ST_IDLE);
  assign maj      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign mid      = tick && (scnt == SC_M2);
  assign scnt_inc = (scnt == SC_LAST) ? '0 : scnt + 1'b1;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (busy),
    .tick (tick)
  );

  // Two-flop synchroniser plus previous-value flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      rxs_prev <= 1'b1;
    end else begin
      sync     <= {sync[0], rx};
      rxs_prev <= sync[1];
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live rxs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (tick) begin
      if (scnt == SC_M0) samp_a <= rxs;
      if (scnt == SC_M1) samp_b <= rxs;
    end
  end

  // Next-state and strobe decisions, evaluated at the mid-bit majority point.
  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    clr        = 1'b0;
    fin_nxt    = 1'b0;
    ferr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rxs_prev && !rxs) begin
          state_nxt = ST_START;
          scnt_nxt  = '0;
          clr       = 1'b1;
        end
      end
      ST_START: begin
        if (tick) scnt_nxt = scnt_inc;
        if (mid) begin
          if (!maj) begin
            state_nxt  = ST_DATA;
            bitcnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) scnt_nxt = scnt_inc;
        if (mid) begin
          shreg_nxt = {maj, shreg[7:1]};
          if (bitcnt == 3'd7) state_nxt = ST_STOP;
          else bitcnt_nxt = bitcnt + 3'd1;
        end
      end
      ST_STOP: begin
        if (tick) scnt_nxt = scnt_inc;
        if (mid) begin
          if (maj) begin
            fin_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_BREAK;
            scnt_nxt  = '0;
          end
        end
      end
      ST_BREAK: begin
        // scnt counts consecutive high ticks; any low sample restarts the wait.
        if (!rxs) begin
          scnt_nxt = '0;
        end else if (tick) begin
          if (scnt == SC_LAST) begin
            state_nxt = ST_IDLE;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rxdata    <= 8'h00;
      rxfinish  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      rxfinish  <= fin_nxt;
      frame_err <= ferr_nxt;
      if (fin_nxt) rxdata <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: expected bytes are queued as frames are
// driven and compared when rxfinish fires.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int  CLK_HZ = 16_000_000;
  localparam int  BAUD   = 250_000;
  localparam int  OS     = 16;
  localparam real CLK_NS = 62.5;
  localparam real BIT_NS = 4000.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxdata;
  logic       rxfinish, frame_err, busy;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         fin_cyc[$];
  int         cyc      = 0;
  int         fin_cnt  = 0;
  int         ferr_cnt = 0;
  logic       prev_fin  = 1'b0;
  logic       prev_ferr = 1'b0;

  uart_byte_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxdata    (rxdata),
    .rxfinish  (rxfinish),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(CLK_NS / 2.0) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on rxfinish, strobe width and exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (rxfinish) begin
        fin_cnt++;
        fin_cyc.push_back(cyc);
        check("fin_width", 32'(prev_fin), 32'd0);
        check("fin_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rxdata", 32'(rxdata), 32'(exp_q.pop_front()));
      end
      if (frame_err) begin
        ferr_cnt++;
        check("ferr_excl", 32'(rxfinish), 32'd0);
        check("ferr_width", 32'(prev_ferr), 32'd0);
      end
    end
    prev_fin  = rxfinish;
    prev_ferr = frame_err;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_c, f0, e0, lat, n;

    // reset state
    idle(5);
    check("rst_rxdata", 32'(rxdata), 32'h00);
    check("rst_rxfinish", 32'(rxfinish), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(10);

    // single byte with latency window
    f0 = fin_cnt;
    fin_cyc.delete();
    start_c = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT_NS);
    wait_drain("t1_drain");
    check("t1_count", 32'(fin_cnt - f0), 32'd1);
    if (fin_cyc.size() > 0) begin
      lat = fin_cyc[0] - start_c;
      check($sformatf("t1_latency_%0d_in_600_630", lat), 32'(lat >= 600 && lat <= 630), 32'd1);
    end
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    idle(50);

    // back-to-back buffer message
    f0 = fin_cnt;
    fin_cyc.delete();
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h09);
    send_byte(8'h03, 1'b1, BIT_NS);
    send_byte(8'h07, 1'b1, BIT_NS);
    send_byte(8'h09, 1'b1, BIT_NS);
    wait_drain("t2_drain");
    check("t2_count", 32'(fin_cnt - f0), 32'd3);
    if (fin_cyc.size() == 3) begin
      check("t2_gap01", 32'(fin_cyc[1] - fin_cyc[0]), 32'd640);
      check("t2_gap12", 32'(fin_cyc[2] - fin_cyc[1]), 32'd640);
    end
    idle(50);

    // glitch start
    f0 = fin_cnt;
    e0 = ferr_cnt;
    rx = 1'b0;
    idle(10);
    check("t3_busy_hi", 32'(busy), 32'd1);
    idle(10);
    rx = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_busy_lo", 32'(busy), 32'd0);
    idle(100);
    check("t3_no_fin", 32'(fin_cnt - f0), 32'd0);
    check("t3_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    check("t3_hold", 32'(rxdata), 32'h09);

    // framing error, then recovery
    f0 = fin_cnt;
    e0 = ferr_cnt;
    send_byte(8'h5A, 1'b0, BIT_NS);
    idle(192);
    check("t4_ferr", 32'(ferr_cnt - e0), 32'd1);
    check("t4_no_fin", 32'(fin_cnt - f0), 32'd0);
    check("t4_hold", 32'(rxdata), 32'h09);
    check("t4_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, BIT_NS);
    wait_drain("t4_drain");
    check("t4_rxdata", 32'(rxdata), 32'h11);
    idle(50);

    // reset in the middle of data bit 4 of 0xFF
    f0 = fin_cnt;
    e0 = ferr_cnt;
    rx = 1'b0;
    idle(64);
    rx = 1'b1;
    idle(4 * 64 + 32);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rxdata", 32'(rxdata), 32'h00);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rxfinish", 32'(rxfinish), 32'd0);
    check("t5_frame_err", 32'(frame_err), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(700);
    check("t5_no_fin", 32'(fin_cnt - f0), 32'd0);
    check("t5_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BIT_NS);
    wait_drain("t5_drain");
    check("t5_rxdata_after", 32'(rxdata), 32'h3C);
    idle(50);

    // baud skew +3% and -3%
    f0 = fin_cnt;
    e0 = ferr_cnt;
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, 1.0e9 / 257_500.0);
    wait_drain("t6_fast_drain");
    check("t6_fast_rxdata", 32'(rxdata), 32'hC3);
    idle(50);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, 1.0e9 / 242_500.0);
    wait_drain("t6_slow_drain");
    check("t6_slow_rxdata", 32'(rxdata), 32'hC3);
    check("t6_count", 32'(fin_cnt - f0), 32'd2);
    check("t6_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
